// File: rtl/arb_pkg.sv
// Shared types and helpers for matrix-based arbiters.
// Supports up to ARB_MAXW requesters.
package arb_pkg;

    localparam int ARB_MAXW  = 32;
    localparam int ARB_MAXIW = $clog2(ARB_MAXW);

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_lock_state_e;

    typedef logic [ARB_MAXW-1:0][ARB_MAXW-1:0] arb_mtx_t;

    // Fixed priority 0 > 1 > ... : j beats i iff j < i.
    function automatic arb_mtx_t arb_mtx_reset(input int width);
        arb_mtx_t m;
        m = '0;
        for (int i = 0; i < ARB_MAXW; i++) begin
            for (int j = 0; j < ARB_MAXW; j++) begin
                if (i < width && j < i) begin
                    m[i][j] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    // OR-encode; exact for one-hot, zero for zero.
    function automatic logic [ARB_MAXIW-1:0] onehot2idx(
        input logic [ARB_MAXW-1:0] oh
    );
        logic [ARB_MAXIW-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAXW; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_MAXIW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_matrix_upd.sv
// Next-state priority matrix: moves the winner to lowest
// priority while keeping the order of everyone else.
module arb_matrix_upd
    import arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] mtx_i [WIDTH],
    input  logic [WIDTH-1:0] win_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] mtx_o [WIDTH]
);

    // Winner row goes all-ones, winner column all-zeros.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            mtx_o[i] = mtx_i[i];
            if (en_i) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (i == j) begin
                        mtx_o[i][j] = 1'b0;
                    end else if (win_i[i]) begin
                        mtx_o[i][j] = 1'b1;
                    end else if (win_i[j]) begin
                        mtx_o[i][j] = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/arb_matrix_lru_ctrl.sv
// Matrix arbiter with LRU rotation and locked multi-beat
// transfers, offering one grant per cycle on valid/ready.
module arb_matrix_lru_ctrl
    import arb_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] v_req,
    input  logic [WIDTH-1:0] v_req_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_grant,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_lock,
    output logic [WIDTH-1:0] vv_matrix [WIDTH]
);

    localparam arb_mtx_t RST_MTX = arb_mtx_reset(WIDTH);

    arb_lock_state_e  state_q, state_d;
    logic [IDXW-1:0]  lock_idx_q, lock_idx_d;
    logic [WIDTH-1:0] mtx_q [WIDTH];
    logic [WIDTH-1:0] mtx_d [WIDTH];

    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] lock_oh;
    logic [WIDTH-1:0] grant;
    logic [WIDTH-1:0] upd_win;
    logic             upd_en;
    logic             vld;
    logic             fire;

    // Requester i wins when no other active requester beats it.
    always_comb begin
        sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sel[i] = v_req[i] & ~|(v_req & mtx_q[i]);
        end
    end

    assign lock_oh = WIDTH'(1) << lock_idx_q;

    // Grant, handshake and next state; reset forces outputs idle.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        grant      = '0;
        vld        = 1'b0;
        fire       = 1'b0;
        upd_en     = 1'b0;
        upd_win    = '0;
        out_lock   = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                ARB_IDLE: begin
                    grant = sel;
                    vld   = |v_req;
                    fire  = vld & out_rdy;
                    if (fire) begin
                        if (|(v_req_last & sel)) begin
                            upd_en  = 1'b1;
                            upd_win = sel;
                        end else begin
                            state_d    = ARB_LOCK;
                            lock_idx_d = IDXW'(onehot2idx(ARB_MAXW'(sel)));
                        end
                    end
                end
                ARB_LOCK: begin
                    out_lock = 1'b1;
                    vld      = v_req[lock_idx_q];
                    grant    = lock_oh & {WIDTH{vld}};
                    fire     = vld & out_rdy;
                    if (fire && v_req_last[lock_idx_q]) begin
                        upd_en  = 1'b1;
                        upd_win = lock_oh;
                        state_d = ARB_IDLE;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    arb_matrix_upd #(
        .WIDTH (WIDTH)
    ) u_upd (
        .mtx_i (mtx_q),
        .win_i (upd_win),
        .en_i  (upd_en),
        .mtx_o (mtx_d)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Priority matrix register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                mtx_q[i] <= RST_MTX[i][WIDTH-1:0];
            end
        end else begin
            mtx_q <= mtx_d;
        end
    end

    assign out_vld   = vld;
    assign out_grant = grant;
    assign out_idx   = IDXW'(onehot2idx(ARB_MAXW'(grant)));
    assign vv_matrix = mtx_q;

endmodule

// File: tb/tb_arb_matrix_lru_ctrl.sv
// Directed and model-checked bench for arb_matrix_lru_ctrl.
// Priority is tracked as an ordered list, highest first.
module tb_arb_matrix_lru_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] v_req;
    logic [3:0] v_req_last;
    logic       out_vld;
    logic       out_rdy;
    logic [3:0] out_grant;
    logic [1:0] out_idx;
    logic       out_lock;
    logic [3:0] vv_matrix [4];

    int total = 0;
    int bad   = 0;
    int order [4];
    bit m_lock;
    int m_lidx;

    always #5 clk = ~clk;

    arb_matrix_lru_ctrl #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_req      (v_req),
        .v_req_last (v_req_last),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_grant  (out_grant),
        .out_idx    (out_idx),
        .out_lock   (out_lock),
        .vv_matrix  (vv_matrix)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic int pos(input int k);
        for (int i = 0; i < 4; i++) if (order[i] == k) return i;
        return 0;
    endfunction

    function automatic logic [15:0] exp_mtx();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i != j && pos(j) < pos(i)) m[i*4+j] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] dut_mtx();
        logic [15:0] m;
        for (int i = 0; i < 4; i++) m[i*4 +: 4] = vv_matrix[i];
        return m;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [3:0] r);
        for (int i = 0; i < 4; i++)
            if (r[order[i]]) return 4'(1) << order[i];
        return 4'b0;
    endfunction

    task automatic lru(input int g);
        int t [4];
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (order[i] != g) begin
                t[n] = order[i];
                n++;
            end
        end
        t[3] = g;
        order = t;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) order[i] = i;
        m_lock = 1'b0;
        m_lidx = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] g1 [5];
    logic [1:0] i1 [5];

    initial begin
        g1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        i1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        mdl_reset();
        rst_n = 1'b0;
        v_req = 4'b1111;
        v_req_last = 4'b1111;
        out_rdy = 1'b1;
        step();
        step();
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_grant", 32'(out_grant), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_lock", 32'(out_lock), 32'd0);
        chk("rst_mtx", 32'(dut_mtx()), 32'h7310);

        // round robin through all four with single beats
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(out_grant), 32'(g1[k]));
            chk("rr_idx", 32'(out_idx), 32'(i1[k]));
            chk("rr_mtx", 32'(dut_mtx()), 32'(exp_mtx()));
            step();
            lru(int'(i1[k]));
        end

        // held grant while stalled
        v_req = 4'b0110;
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall_grant", 32'(out_grant), 32'b0010);
            chk("stall_mtx", 32'(dut_mtx()), 32'(exp_mtx()));
            step();
        end
        out_rdy = 1'b1;
        #1;
        chk("stall_fire", 32'(out_grant), 32'b0010);
        chk("stall_mtx2", 32'(dut_mtx()), 32'(exp_mtx()));
        step();
        lru(1);
        out_rdy = 1'b0;
        #1;
        chk("stall_next", 32'(out_grant), 32'b0100);
        chk("stall_upd", 32'(dut_mtx()), 32'(exp_mtx()));

        // four-beat locked transfer by requester 0
        v_req = 4'b0011;
        v_req_last = 4'b0000;
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) v_req_last = 4'b0001;
            #1;
            chk("lk_grant", 32'(out_grant), 32'b0001);
            chk("lk_lock", 32'(out_lock), (k == 0) ? 32'd0 : 32'd1);
            step();
        end
        lru(0);
        out_rdy = 1'b0;
        #1;
        chk("lk_after", 32'(out_grant), 32'b0010);
        chk("lk_unlock", 32'(out_lock), 32'd0);
        chk("lk_mtx", 32'(dut_mtx()), 32'(exp_mtx()));

        // holder 2 drops its request while locked
        v_req = 4'b0100;
        v_req_last = 4'b0000;
        out_rdy = 1'b1;
        #1;
        chk("drop_first", 32'(out_grant), 32'b0100);
        step();
        v_req = 4'b1011;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("drop_vld", 32'(out_vld), 32'd0);
            chk("drop_lock", 32'(out_lock), 32'd1);
            chk("drop_grant", 32'(out_grant), 32'd0);
            chk("drop_idx", 32'(out_idx), 32'd0);
            step();
        end
        v_req = 4'b1111;
        v_req_last = 4'b0100;
        #1;
        chk("drop_back", 32'(out_grant), 32'b0100);
        chk("drop_bidx", 32'(out_idx), 32'd2);
        step();
        lru(2);
        out_rdy = 1'b0;
        #1;
        chk("drop_idle", 32'(out_lock), 32'd0);
        chk("drop_next", 32'(out_grant), 32'b1000);
        chk("drop_mtx", 32'(dut_mtx()), 32'(exp_mtx()));

        // reset in the middle of a locked transfer
        v_req_last = 4'b0000;
        out_rdy = 1'b1;
        step();
        chk("mr_lock", 32'(out_lock), 32'd1);
        chk("mr_grant", 32'(out_grant), 32'b1000);
        rst_n = 1'b0;
        #1;
        chk("mr_rvld", 32'(out_vld), 32'd0);
        chk("mr_rlock", 32'(out_lock), 32'd0);
        chk("mr_rgrant", 32'(out_grant), 32'd0);
        step();
        rst_n = 1'b1;
        out_rdy = 1'b0;
        mdl_reset();
        #1;
        chk("mr_lock2", 32'(out_lock), 32'd0);
        chk("mr_mtx", 32'(dut_mtx()), 32'h7310);
        chk("mr_grant2", 32'(out_grant), 32'b0001);
        step();

        // random traffic against the ordered-list model
        for (int n = 0; n < 2000; n++) begin
            logic [3:0] eg;
            int gi;
            v_req = 4'($urandom);
            v_req_last = 4'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (m_lock) eg = v_req[m_lidx] ? 4'(1) << m_lidx : 4'b0;
            else eg = exp_sel(v_req);
            gi = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) gi = i;
            chk("rnd_grant", 32'(out_grant), 32'(eg));
            chk("rnd_idx", 32'(out_idx), 32'(gi));
            chk("rnd_vld", 32'(out_vld), 32'(|eg));
            chk("rnd_lock", 32'(out_lock), 32'(m_lock));
            chk("rnd_mtx", 32'(dut_mtx()), 32'(exp_mtx()));
            step();
            if (|eg && out_rdy) begin
                if (v_req_last[gi]) begin
                    lru(gi);
                    m_lock = 1'b0;
                end else if (!m_lock) begin
                    m_lock = 1'b1;
                    m_lidx = gi;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
